oport_uart_tx: RTL and testbench

//  Downstream consumer of the computer's 8-bit output port (oport). Each new value

---
 rtl/oport_uart_tx_pkg.sv | 6 +
 rtl/oport_uart_tx_byte_fifo.sv | 42 ++++
 rtl/oport_uart_tx.sv | 84 ++++++++
 tb/tb_oport_uart_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/oport_uart_tx_pkg.sv
// oport_uart_tx_pkg: shared symbols for the output-port UART transmitter.
package oport_uart_tx_pkg;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   localparam logic [7:0] PREV_RST = 8'h00;
   localparam int DATA_BITS = 8;
endpackage

// File: rtl/oport_uart_tx_byte_fifo.sv
// byte_fifo: synchronous show-ahead FIFO; a push when full is accepted only alongside a pop.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [LW-1:0]    r_level;
   logic             w_wr, w_rd;
   assign w_rd  = pop & ~empty;
   assign w_wr  = push & (~full | w_rd);
   assign full  = r_level == LW'(DEPTH);
   assign empty = r_level == '0;
   assign dout  = r_mem[r_rd];
   assign level = r_level;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         r_wr    <= w_wr ? r_wr + 1'b1 : r_wr;
         r_rd    <= w_rd ? r_rd + 1'b1 : r_rd;
         r_level <= r_level + LW'(w_wr) - LW'(w_rd);
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr] <= din;
   end
endmodule

// File: rtl/oport_uart_tx.sv
// oport_uart_tx: queues every change of the CPU output port and sends it as an 8N1 frame on txd.
module oport_uart_tx
   import oport_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    oport,
   input  logic                          tx_en,
   input  logic                          ovf_clr,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   tx_state_t      r_state, w_state_nxt;
   logic [7:0]     r_prev, r_shift, w_shift_nxt, w_dout;
   logic [BW-1:0]  r_baud;
   logic [2:0]     r_bit;
   logic           r_txd, r_busy, r_ovf;
   logic           w_push, w_push_ok, w_pop, w_full, w_empty, w_baud_last, w_txd_nxt, w_busy_nxt;
   logic [LW-1:0]  w_level_nxt;
   assign w_push      = tx_en & (oport != r_prev);
   assign w_push_ok   = w_push & (~w_full | w_pop);
   assign w_baud_last = r_baud == BW'(CLKS_PER_BIT - 1);
   assign w_level_nxt = level + LW'(w_push_ok) - LW'(w_pop);
   byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (oport),
      .pop   (w_pop),
      .dout  (w_dout),
      .level (level),
      .full  (w_full),
      .empty (w_empty)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= TX_IDLE;
      else        r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TX_IDLE:  if (!w_empty) w_state_nxt = TX_START;
         TX_START: if (w_baud_last) w_state_nxt = TX_DATA;
         TX_DATA:  if (w_baud_last && r_bit == 3'd7) w_state_nxt = TX_STOP;
         default:  if (w_baud_last) w_state_nxt = w_empty ? TX_IDLE : TX_START;
      endcase
   end
   // txd and busy are computed one cycle ahead so the registered copies line up with the state
   always_comb begin
      w_pop       = ~w_empty & ((r_state == TX_IDLE) | ((r_state == TX_STOP) & w_baud_last));
      w_shift_nxt = w_pop ? w_dout : ((r_state == TX_DATA) & w_baud_last) ? {1'b0, r_shift[7:1]} : r_shift;
      w_txd_nxt   = (w_state_nxt == TX_START) ? 1'b0 : (w_state_nxt == TX_DATA) ? w_shift_nxt[0] : 1'b1;
      w_busy_nxt  = (w_state_nxt != TX_IDLE) | (w_level_nxt != '0);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev  <= PREV_RST;
         r_shift <= '0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_prev  <= oport;
         r_shift <= w_shift_nxt;
         r_baud  <= ((r_state == TX_IDLE) | w_baud_last) ? '0 : r_baud + 1'b1;
         r_bit   <= ((r_state == TX_DATA) & w_baud_last) ? r_bit + 3'd1 : r_bit;
         r_txd   <= w_txd_nxt;
         r_busy  <= w_busy_nxt;
         r_ovf   <= (w_push & ~w_push_ok) | (r_ovf & ~ovf_clr);
      end
   end
   assign txd      = r_txd;
   assign busy     = r_busy;
   assign overflow = r_ovf;
endmodule

// File: tb/tb_oport_uart_tx.sv
// tb_oport_uart_tx: directed scenarios plus random traffic, checked every cycle against a frame-level model.
module tb_oport_uart_tx;
   localparam int C  = 4;
   localparam int D  = 4;
   localparam int FL = 10 * C;
   logic       clk = 0, reset = 0, tx_en = 0, ovf_clr = 0;
   logic [7:0] oport = 8'h00;
   logic       txd, busy, overflow;
   logic [2:0] level;
   int         n_chk = 0, n_err = 0;
   logic [7:0] m_prev = 8'h00, m_cur = 8'h00;
   logic [7:0] m_q[$];
   bit         m_act = 0, m_ovf = 0, m_push, m_pop, m_drop;
   int         m_t = 0;
   logic [7:0] b_a5 = 8'hA5, b_5a = 8'h5A;
   int         pk, gap, rises;
   logic       prev_busy;
   oport_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .reset    (reset),
      .oport    (oport),
      .tx_en    (tx_en),
      .ovf_clr  (ovf_clr),
      .txd      (txd),
      .busy     (busy),
      .level    (level),
      .overflow (overflow)
   );
   always #5 clk = ~clk;
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   // line level at position m_t of the current frame: start, 8 data bits LSB first, stop
   function automatic logic m_txd();
      if (!m_act) return 1'b1;
      if (m_t < C) return 1'b0;
      if (m_t < 9 * C) return m_cur[(m_t - C) / C];
      return 1'b1;
   endfunction
   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_prev = 8'h00; m_q.delete(); m_act = 0; m_t = 0; m_ovf = 0;
      end else begin
         m_push = tx_en && (oport != m_prev);
         m_prev = oport;
         m_pop  = (m_q.size() != 0) && (!m_act || m_t == FL - 1);
         m_drop = m_push && (m_q.size() == D) && !m_pop;
         if (m_pop) begin
            m_cur = m_q.pop_front(); m_act = 1; m_t = 0;
         end else if (m_act) begin
            if (m_t == FL - 1) m_act = 0;
            else m_t++;
         end
         if (m_push && !m_drop) m_q.push_back(oport);
         m_ovf = m_drop ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
      end
   end
   initial forever begin
      @(negedge clk);
      check("txd", txd, m_txd());
      check("level", level, m_q.size());
      check("busy", busy, m_act || m_q.size() != 0);
      check("overflow", overflow, m_ovf);
   end
   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_idle(int lim);
      int k = 0;
      while ((busy || m_act || m_q.size() != 0) && k < lim) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", k < lim, 1);
   endtask
   initial begin
      tick(3);
      reset = 1; tx_en = 1;
      tick(100);
      check("t1_txd", txd, 1);
      check("t1_busy", busy, 0);
      check("t1_level", level, 0);
      oport = 8'hA5;
      for (int k = 1; k <= 42; k++) begin
         @(negedge clk);
         check("t2_txd", txd, k < 2 ? 1 : k < 6 ? 0 : k < 38 ? b_a5[(k - 6) / 4] : 1);
         if (k == 41) check("t2_busy_hi", busy, 1);
      end
      check("t2_busy_lo", busy, 0);
      tick(5);
      oport = 8'h11; tick(1);
      oport = 8'h22; tick(1);
      oport = 8'h33;
      pk = 0; gap = 0;
      for (int k = 0; k < 110; k++) begin
         @(negedge clk);
         if (int'(level) > pk) pk = int'(level);
         if (!busy) gap++;
      end
      check("t3_peak", pk, 2);
      check("t3_gap", gap, 0);
      wait_idle(200);
      for (int i = 0; i < 6; i++) begin
         oport = 8'h41 + 8'(i); tick(1);
      end
      check("t4_ovf_set", overflow, 1);
      check("t4_level", level, 4);
      tick(3);
      ovf_clr = 1; tick(1); ovf_clr = 0;
      check("t4_ovf_clr", overflow, 0);
      wait_idle(300);
      for (int i = 0; i < 6; i++) begin
         oport = 8'h51 + 8'(i); ovf_clr = (i == 5); tick(1);
      end
      ovf_clr = 0;
      check("t4_set_wins", overflow, 1);
      wait_idle(300);
      ovf_clr = 1; tick(1); ovf_clr = 0;
      tx_en = 0; oport = 8'h3C; tick(5);
      tx_en = 1; gap = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (busy) gap++;
      end
      check("t5_no_frame", gap, 0);
      oport = 8'h3D; rises = 0; prev_busy = busy;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
      end
      check("t5_one_frame", rises, 1);
      wait_idle(100);
      oport = 8'h5A;
      tick(19);
      check("t6_bit3", txd, b_5a[3]);
      #2 reset = 0;
      #1;
      check("t6_txd_async", txd, 1);
      check("t6_level", level, 0);
      check("t6_busy", busy, 0);
      oport = 8'h00;
      tick(3);
      reset = 1; gap = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (busy || !txd) gap++;
      end
      check("t6_quiet", gap, 0);
      for (int k = 0; k < 3000; k++) begin
         tx_en   = $urandom_range(0, 9) != 0;
         ovf_clr = $urandom_range(0, 24) == 0;
         if ($urandom_range(0, 7) == 0) oport = 8'($urandom);
         tick(1);
      end
      ovf_clr = 0;
      wait_idle(400);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
